// File: rtl/usb_ep_pkg.sv
// Shared types for the USB endpoint blocks: response codes, data PIDs and the
// IN packetizer state encoding.
package usb_ep_pkg;

    localparam int unsigned DefaultMaxPacketSize = 64;

    typedef enum logic [1:0] {
        RESP_DATA  = 2'd0,
        RESP_NAK   = 2'd1,
        RESP_STALL = 2'd2
    } respType_e;

    typedef enum logic {
        DATA0 = 1'b0,
        DATA1 = 1'b1
    } dataPid_e;

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StLook,
        StPresent,
        StWaitHs
    } inPktState_e;

endpackage

// File: rtl/usb_ep_in_packetizer.sv
// IN endpoint packetizer: answers each IN token with DATA/NAK/STALL, streams up
// to MAX_PACKET_SIZE committed FIFO bytes to the transmitter, and afterwards
// commits the popped bytes on ACK or rolls them back so the packet is resent.
module usb_ep_in_packetizer
    import usb_ep_pkg::*;
#(
    parameter int unsigned MAX_PACKET_SIZE = DefaultMaxPacketSize,
    parameter int unsigned CNT_WID         = $clog2(MAX_PACKET_SIZE + 1)
) (
    input  logic       clk48_i,
    input  logic       rst_i,
    input  logic       inToken_i,
    input  logic       stall_i,
    input  logic       resetToggle_i,
    output logic       respValid_o,
    output logic [1:0] respType_o,
    output logic       dataPid_o,
    output logic       txValid_o,
    output logic [7:0] txData_o,
    output logic       txLast_o,
    input  logic       txReady_i,
    input  logic       txAbort_i,
    input  logic       hsAck_i,
    input  logic       hsTimeout_i,
    input  logic       fifoDataAvailable_i,
    input  logic [7:0] fifoData_i,
    output logic       fifoPop_o,
    output logic       fifoPopTransDone_o,
    output logic       fifoPopTransSuccess_o,
    output logic       busy_o
);

    localparam logic [CNT_WID-1:0] MaxCount = CNT_WID'(MAX_PACKET_SIZE);

    inPktState_e        state_q, state_d;
    dataPid_e           toggle_q;
    dataPid_e           dataPid_q;
    respType_e          respType_q;
    logic               respValid_q;
    logic [CNT_WID-1:0] count_q;
    logic [7:0]         hold_q;
    logic               last_q;

    assign respValid_o = respValid_q;
    assign respType_o  = respType_q;
    assign dataPid_o   = dataPid_q;

    // State register.
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; an abort from the transmitter wins over a byte accept.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (inToken_i && !stall_i && fifoDataAvailable_i) begin
                    state_d = StFetch;
                end
            end
            StFetch:   state_d = txAbort_i ? StIdle : StLook;
            StLook:    state_d = txAbort_i ? StIdle : StPresent;
            StPresent: begin
                if (txAbort_i) begin
                    state_d = StIdle;
                end else if (txReady_i) begin
                    state_d = last_q ? StWaitHs : StFetch;
                end
            end
            StWaitHs: begin
                if (hsAck_i || hsTimeout_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs: state-decoded strobes plus the commit/rollback pulse that follows
    // the handshake or abort input in the same cycle.
    always_comb begin
        fifoPop_o             = 1'b0;
        txValid_o             = 1'b0;
        txData_o              = 8'h00;
        txLast_o              = 1'b0;
        fifoPopTransDone_o    = 1'b0;
        fifoPopTransSuccess_o = 1'b0;
        busy_o                = (state_q != StIdle);
        unique case (state_q)
            StIdle: ;
            StFetch: begin
                // No pop alongside a rollback, so the FIFO sees one clean operation.
                fifoPop_o          = !txAbort_i;
                fifoPopTransDone_o = txAbort_i;
            end
            StLook: fifoPopTransDone_o = txAbort_i;
            StPresent: begin
                txValid_o          = 1'b1;
                txData_o           = hold_q;
                txLast_o           = last_q;
                fifoPopTransDone_o = txAbort_i;
            end
            StWaitHs: begin
                fifoPopTransDone_o    = hsAck_i || hsTimeout_i;
                fifoPopTransSuccess_o = hsAck_i;
            end
            default: ;
        endcase
    end

    // Datapath: token response, byte hold/count, end-of-packet latch, data toggle.
    always_ff @(posedge clk48_i) begin
        if (rst_i) begin
            respValid_q <= 1'b0;
            respType_q  <= RESP_DATA;
            dataPid_q   <= DATA0;
            toggle_q    <= DATA0;
            count_q     <= '0;
            hold_q      <= 8'h00;
            last_q      <= 1'b0;
        end else begin
            respValid_q <= 1'b0;
            respType_q  <= RESP_DATA;
            dataPid_q   <= DATA0;
            if (state_q == StIdle && inToken_i) begin
                respValid_q <= 1'b1;
                if (stall_i) begin
                    respType_q <= RESP_STALL;
                end else if (!fifoDataAvailable_i) begin
                    respType_q <= RESP_NAK;
                end else begin
                    respType_q <= RESP_DATA;
                    dataPid_q  <= toggle_q;
                    count_q    <= '0;
                end
            end
            if (fifoPop_o) begin
                hold_q  <= fifoData_i;
                count_q <= count_q + 1'b1;
            end
            // Latched once per byte; bytes committed later never extend this packet.
            if (state_q == StLook) begin
                last_q <= (count_q == MaxCount) || !fifoDataAvailable_i;
            end
            if (resetToggle_i) begin
                toggle_q <= DATA0;
            end else if (state_q == StWaitHs && hsAck_i) begin
                toggle_q <= (toggle_q == DATA0) ? DATA1 : DATA0;
            end
        end
    end

endmodule

// File: tb/tb_usb_ep_in_packetizer.sv
// Bench for usb_ep_in_packetizer: a commit/rollback FIFO model feeds the DUT and
// a queue-based reference model predicts responses, payloads and data toggles.
module tb_usb_ep_in_packetizer;

    localparam int unsigned Mps = 8;
    localparam logic [1:0] RespData  = 2'd0;
    localparam logic [1:0] RespNak   = 2'd1;
    localparam logic [1:0] RespStall = 2'd2;

    logic       clk;
    logic       rst_i;
    logic       inToken_i;
    logic       stall_i;
    logic       resetToggle_i;
    logic       respValid_o;
    logic [1:0] respType_o;
    logic       dataPid_o;
    logic       txValid_o;
    logic [7:0] txData_o;
    logic       txLast_o;
    logic       txReady_i;
    logic       txAbort_i;
    logic       hsAck_i;
    logic       hsTimeout_i;
    logic       fifoDataAvailable_i;
    logic [7:0] fifoData_i;
    logic       fifoPop_o;
    logic       fifoPopTransDone_o;
    logic       fifoPopTransSuccess_o;
    logic       busy_o;

    int checks;
    int errors;

    usb_ep_in_packetizer #(
        .MAX_PACKET_SIZE(Mps)
    ) dut (
        .clk48_i              (clk),
        .rst_i                (rst_i),
        .inToken_i            (inToken_i),
        .stall_i              (stall_i),
        .resetToggle_i        (resetToggle_i),
        .respValid_o          (respValid_o),
        .respType_o           (respType_o),
        .dataPid_o            (dataPid_o),
        .txValid_o            (txValid_o),
        .txData_o             (txData_o),
        .txLast_o             (txLast_o),
        .txReady_i            (txReady_i),
        .txAbort_i            (txAbort_i),
        .hsAck_i              (hsAck_i),
        .hsTimeout_i          (hsTimeout_i),
        .fifoDataAvailable_i  (fifoDataAvailable_i),
        .fifoData_i           (fifoData_i),
        .fifoPop_o            (fifoPop_o),
        .fifoPopTransDone_o   (fifoPopTransDone_o),
        .fifoPopTransSuccess_o(fifoPopTransSuccess_o),
        .busy_o               (busy_o)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // FIFO model: read pointer advances on pop, base pointer marks the last commit.
    logic [7:0] mem [1024];
    int wrPtr;
    int rdPtr;
    int basePtr;
    int popCount;
    int commitCount;
    int rollbackCount;

    assign fifoDataAvailable_i = (rdPtr < wrPtr);
    assign fifoData_i          = mem[rdPtr[9:0]];

    always @(posedge clk) begin
        if (fifoPop_o) popCount <= popCount + 1;
        if (fifoPopTransDone_o && fifoPopTransSuccess_o) commitCount <= commitCount + 1;
        if (fifoPopTransDone_o && !fifoPopTransSuccess_o) rollbackCount <= rollbackCount + 1;
        if (rst_i) begin
            rdPtr   <= 0;
            basePtr <= 0;
        end else begin
            if (fifoPop_o) rdPtr <= rdPtr + 1;
            if (fifoPopTransDone_o) begin
                if (fifoPopTransSuccess_o) basePtr <= rdPtr;
                else rdPtr <= basePtr;
            end
        end
    end

    // Reference model: bytes not yet acknowledged, plus the expected data toggle.
    logic [7:0] modelQ [$];
    logic       modelToggle;

    // Observations of the most recent transaction.
    logic       obsValid;
    logic [1:0] obsType;
    logic       obsPid;
    logic [7:0] rxBytes [$];
    logic       rxDone;
    int         rxUnstable;
    logic       hsDone;
    logic       hsSucc;

    function automatic int expLen();
        return (modelQ.size() < int'(Mps)) ? modelQ.size() : int'(Mps);
    endfunction

    function automatic int payloadDiffs(input int n);
        int d = 0;
        if (rxBytes.size() != n) d++;
        for (int i = 0; i < n && i < rxBytes.size(); i++) begin
            if (rxBytes[i] !== modelQ[i]) d++;
        end
        return d;
    endfunction

    task automatic modelAck(input int n);
        for (int i = 0; i < n; i++) void'(modelQ.pop_front());
        modelToggle = ~modelToggle;
    endtask

    task automatic pushByte(input logic [7:0] b);
        mem[wrPtr[9:0]] = b;
        wrPtr = wrPtr + 1;
        modelQ.push_back(b);
    endtask

    task automatic doReset();
        rst_i = 1'b1;
        wrPtr = 0;
        modelQ.delete();
        modelToggle = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic sendToken(output logic v, output logic [1:0] t, output logic p);
        inToken_i = 1'b1;
        @(negedge clk);
        inToken_i = 1'b0;
        v = respValid_o;
        t = respType_o;
        p = dataPid_o;
    endtask

    // Collects one packet under random backpressure; ends in the handshake wait.
    task automatic recvPacket(input int readyPct);
        logic       havePrev;
        logic [7:0] prevData;
        logic       prevLast;
        logic       rdy;
        rxBytes.delete();
        rxDone     = 1'b0;
        rxUnstable = 0;
        havePrev   = 1'b0;
        prevData   = 8'h00;
        prevLast   = 1'b0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            @(negedge clk);
            if (havePrev && !(txValid_o === 1'b1 && txData_o === prevData &&
                              txLast_o === prevLast)) begin
                rxUnstable++;
            end
            havePrev = 1'b0;
            if (txValid_o === 1'b1) begin
                rdy = (int'($urandom_range(99)) < readyPct);
                txReady_i = rdy;
                if (rdy) begin
                    rxBytes.push_back(txData_o);
                    if (txLast_o === 1'b1) begin
                        @(negedge clk);
                        txReady_i = 1'b0;
                        rxDone = 1'b1;
                        break;
                    end
                end else begin
                    havePrev = 1'b1;
                    prevData = txData_o;
                    prevLast = txLast_o;
                end
            end else begin
                txReady_i = 1'b0;
            end
        end
        txReady_i = 1'b0;
    endtask

    task automatic handshake(input logic ack, input logic tmo, output logic d, output logic s);
        hsAck_i     = ack;
        hsTimeout_i = tmo;
        #1;
        d = fifoPopTransDone_o;
        s = fifoPopTransSuccess_o;
        @(negedge clk);
        hsAck_i     = 1'b0;
        hsTimeout_i = 1'b0;
    endtask

    task automatic runTransaction(input int readyPct, input logic ack, input logic tmo,
                                  input logic rtAtHs);
        sendToken(obsValid, obsType, obsPid);
        rxBytes.delete();
        rxDone = 1'b0;
        hsDone = 1'b0;
        hsSucc = 1'b0;
        if (obsValid === 1'b1 && obsType === RespData) begin
            recvPacket(readyPct);
            if (rxDone) begin
                resetToggle_i = rtAtHs;
                handshake(ack, tmo, hsDone, hsSucc);
                resetToggle_i = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({respValid_o, respType_o, dataPid_o, txValid_o, txData_o, txLast_o, fifoPop_o,
             fifoPopTransDone_o, fifoPopTransSuccess_o, busy_o} !== 18'h0) begin
            errors++;
            $display("FAIL reset_outputs: got resp=%b type=%0d pid=%b txv=%b data=%h last=%b pop=%b done=%b succ=%b busy=%b, want all 0",
                     respValid_o, respType_o, dataPid_o, txValid_o, txData_o, txLast_o,
                     fifoPop_o, fifoPopTransDone_o, fifoPopTransSuccess_o, busy_o);
        end
        checks++;
        if (popCount !== 0 || commitCount !== 0 || rollbackCount !== 0) begin
            errors++;
            $display("FAIL reset_fifo_ops: got pops=%0d commits=%0d rollbacks=%0d, want 0",
                     popCount, commitCount, rollbackCount);
        end
    endtask

    task automatic test_mps_split();
        int n;
        for (int i = 0; i < 10; i++) pushByte(8'(i));
        for (int pkt = 0; pkt < 2; pkt++) begin
            n = expLen();
            runTransaction(100, 1'b1, 1'b0, 1'b0);
            checks++;
            if (!(obsValid === 1'b1 && obsType === RespData && obsPid === modelToggle)) begin
                errors++;
                $display("FAIL split_resp%0d: got valid=%b type=%0d pid=%b, want 1 DATA pid=%b",
                         pkt, obsValid, obsType, obsPid, modelToggle);
            end
            checks++;
            if (!rxDone || payloadDiffs(n) != 0) begin
                errors++;
                $display("FAIL split_payload%0d: got %0d bytes (%0d diffs, done=%b), want %0d bytes",
                         pkt, rxBytes.size(), payloadDiffs(n), rxDone, n);
            end
            checks++;
            if (!(hsDone === 1'b1 && hsSucc === 1'b1)) begin
                errors++;
                $display("FAIL split_commit%0d: got done=%b succ=%b, want 1 1", pkt, hsDone, hsSucc);
            end
            modelAck(n);
        end
    endtask

    task automatic test_nak();
        int p0;
        int n;
        p0 = popCount;
        sendToken(obsValid, obsType, obsPid);
        repeat (3) @(negedge clk);
        checks++;
        if (!(obsValid === 1'b1 && obsType === RespNak && popCount == p0 && busy_o === 1'b0)) begin
            errors++;
            $display("FAIL nak: got valid=%b type=%0d pops=%0d busy=%b, want 1 NAK 0 0",
                     obsValid, obsType, popCount - p0, busy_o);
        end
        pushByte(8'h5A);
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(obsType === RespData && obsPid === modelToggle && payloadDiffs(n) == 0)) begin
            errors++;
            $display("FAIL nak_toggle_kept: got type=%0d pid=%b diffs=%0d, want DATA pid=%b",
                     obsType, obsPid, payloadDiffs(n), modelToggle);
        end
        modelAck(n);
    endtask

    task automatic test_stall();
        int p0;
        int n;
        for (int i = 0; i < 5; i++) pushByte(8'(8'h30 + i));
        stall_i = 1'b1;
        p0 = popCount;
        sendToken(obsValid, obsType, obsPid);
        repeat (3) @(negedge clk);
        checks++;
        if (!(obsValid === 1'b1 && obsType === RespStall && popCount == p0 && busy_o === 1'b0)) begin
            errors++;
            $display("FAIL stall: got valid=%b type=%0d pops=%0d busy=%b, want 1 STALL 0 0",
                     obsValid, obsType, popCount - p0, busy_o);
        end
        stall_i = 1'b0;
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(obsType === RespData && obsPid === modelToggle && rxDone && payloadDiffs(n) == 0)) begin
            errors++;
            $display("FAIL stall_untouched: got type=%0d pid=%b bytes=%0d diffs=%0d, want DATA pid=%b %0d bytes",
                     obsType, obsPid, rxBytes.size(), payloadDiffs(n), modelToggle, n);
        end
        modelAck(n);
    endtask

    task automatic test_timeout_retry();
        int n;
        logic firstPid;
        pushByte(8'hA1);
        pushByte(8'hA2);
        pushByte(8'hA3);
        n = expLen();
        firstPid = modelToggle;
        runTransaction(100, 1'b0, 1'b1, 1'b0);
        checks++;
        if (!(obsPid === modelToggle && rxDone && payloadDiffs(n) == 0 &&
              hsDone === 1'b1 && hsSucc === 1'b0)) begin
            errors++;
            $display("FAIL timeout_first: got pid=%b diffs=%0d done=%b succ=%b, want pid=%b 0 1 0",
                     obsPid, payloadDiffs(n), hsDone, hsSucc, modelToggle);
        end
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(obsPid === firstPid && rxDone && payloadDiffs(n) == 0 && hsSucc === 1'b1)) begin
            errors++;
            $display("FAIL timeout_retry: got pid=%b diffs=%0d succ=%b, want pid=%b 0 1",
                     obsPid, payloadDiffs(n), hsSucc, firstPid);
        end
        modelAck(n);
    endtask

    task automatic test_backpressure();
        int n;
        logic tmo;
        for (int iter = 0; iter < 6; iter++) begin
            n = int'($urandom_range(1, 20));
            for (int i = 0; i < n; i++) pushByte(8'($urandom));
            for (int k = 0; k < 12 && modelQ.size() > 0; k++) begin
                n = expLen();
                tmo = ($urandom_range(3) == 0);
                runTransaction(int'($urandom_range(30, 90)), !tmo, tmo, 1'b0);
                checks++;
                if (!(obsType === RespData && obsPid === modelToggle && rxDone &&
                      payloadDiffs(n) == 0 && rxUnstable == 0)) begin
                    errors++;
                    $display("FAIL bp_packet%0d_%0d: got pid=%b bytes=%0d diffs=%0d unstable=%0d, want pid=%b %0d bytes",
                             iter, k, obsPid, rxBytes.size(), payloadDiffs(n), rxUnstable,
                             modelToggle, n);
                end
                checks++;
                if (!(hsDone === 1'b1 && hsSucc === !tmo)) begin
                    errors++;
                    $display("FAIL bp_hs%0d_%0d: got done=%b succ=%b, want 1 %b",
                             iter, k, hsDone, hsSucc, !tmo);
                end
                if (!tmo) modelAck(n);
            end
        end
    endtask

    task automatic test_abort();
        int got;
        int p0;
        int n;
        logic d;
        logic s;
        for (int i = 0; i < 5; i++) pushByte(8'(8'hC0 + i));
        sendToken(obsValid, obsType, obsPid);
        got = 0;
        for (int cyc = 0; cyc < 50 && got < 2; cyc++) begin
            @(negedge clk);
            txReady_i = txValid_o;
            if (txValid_o === 1'b1) got++;
        end
        @(negedge clk);
        txReady_i = 1'b0;
        txAbort_i = 1'b1;
        #1;
        d = fifoPopTransDone_o;
        s = fifoPopTransSuccess_o;
        @(negedge clk);
        txAbort_i = 1'b0;
        checks++;
        if (!(got == 2 && d === 1'b1 && s === 1'b0 && busy_o === 1'b0 && txValid_o === 1'b0)) begin
            errors++;
            $display("FAIL abort: got bytes=%0d done=%b succ=%b busy=%b txv=%b, want 2 1 0 0 0",
                     got, d, s, busy_o, txValid_o);
        end
        p0 = popCount;
        repeat (4) @(negedge clk);
        checks++;
        if (popCount != p0) begin
            errors++;
            $display("FAIL abort_idle_pops: got %0d pops, want 0", popCount - p0);
        end
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(obsPid === modelToggle && rxDone && payloadDiffs(n) == 0)) begin
            errors++;
            $display("FAIL abort_resend: got pid=%b bytes=%0d diffs=%0d, want pid=%b %0d bytes",
                     obsPid, rxBytes.size(), payloadDiffs(n), modelToggle, n);
        end
        modelAck(n);
    endtask

    task automatic test_ack_timeout_same();
        int p0;
        int n;
        pushByte(8'h11);
        pushByte(8'h22);
        n = expLen();
        runTransaction(100, 1'b1, 1'b1, 1'b0);
        p0 = popCount;
        repeat (3) @(negedge clk);
        checks++;
        if (!(rxDone && payloadDiffs(n) == 0 && hsDone === 1'b1 && hsSucc === 1'b1 &&
              busy_o === 1'b0 && popCount == p0)) begin
            errors++;
            $display("FAIL ack_wins: got diffs=%0d done=%b succ=%b busy=%b pops=%0d, want 0 1 1 0 0",
                     payloadDiffs(n), hsDone, hsSucc, busy_o, popCount - p0);
        end
        modelAck(n);
    endtask

    task automatic makeToggleOne();
        int n;
        if (modelToggle == 1'b0) begin
            pushByte(8'hEE);
            n = expLen();
            runTransaction(100, 1'b1, 1'b0, 1'b0);
            checks++;
            if (!(obsPid === 1'b0 && hsSucc === 1'b1)) begin
                errors++;
                $display("FAIL toggle_setup: got pid=%b succ=%b, want 0 1", obsPid, hsSucc);
            end
            modelAck(n);
        end
    endtask

    task automatic test_reset_toggle();
        int n;
        makeToggleOne();
        @(negedge clk);
        resetToggle_i = 1'b1;
        @(negedge clk);
        resetToggle_i = 1'b0;
        modelToggle = 1'b0;
        pushByte(8'h77);
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obsPid !== modelToggle) begin
            errors++;
            $display("FAIL reset_toggle: got pid=%b, want %b", obsPid, modelToggle);
        end
        modelAck(n);
        // Toggle is now DATA1; a reset in the same cycle as the ACK must win.
        pushByte(8'h78);
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < n; i++) void'(modelQ.pop_front());
        modelToggle = 1'b0;
        pushByte(8'h79);
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (obsPid !== modelToggle) begin
            errors++;
            $display("FAIL reset_toggle_priority: got pid=%b, want %b", obsPid, modelToggle);
        end
        modelAck(n);
    endtask

    task automatic test_reset_mid();
        int p0;
        int n;
        makeToggleOne();
        for (int i = 0; i < 4; i++) pushByte(8'(8'h90 + i));
        sendToken(obsValid, obsType, obsPid);
        for (int cyc = 0; cyc < 20 && txValid_o !== 1'b1; cyc++) @(negedge clk);
        checks++;
        if (txValid_o !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_reach: got txValid=%b, want 1", txValid_o);
        end
        rst_i = 1'b1;
        wrPtr = 0;
        @(negedge clk);
        rst_i = 1'b0;
        modelQ.delete();
        modelToggle = 1'b0;
        checks++;
        if ({respValid_o, respType_o, dataPid_o, txValid_o, txData_o, txLast_o, fifoPop_o,
             fifoPopTransDone_o, fifoPopTransSuccess_o, busy_o} !== 18'h0) begin
            errors++;
            $display("FAIL rst_mid_outputs: got txv=%b data=%h last=%b pop=%b busy=%b, want all 0",
                     txValid_o, txData_o, txLast_o, fifoPop_o, busy_o);
        end
        p0 = popCount;
        repeat (3) @(negedge clk);
        checks++;
        if (popCount != p0) begin
            errors++;
            $display("FAIL rst_mid_pops: got %0d pops, want 0", popCount - p0);
        end
        pushByte(8'h44);
        pushByte(8'h55);
        n = expLen();
        runTransaction(100, 1'b1, 1'b0, 1'b0);
        checks++;
        if (!(obsPid === 1'b0 && rxDone && payloadDiffs(n) == 0)) begin
            errors++;
            $display("FAIL rst_mid_after: got pid=%b bytes=%0d diffs=%0d, want pid=0 %0d bytes",
                     obsPid, rxBytes.size(), payloadDiffs(n), n);
        end
        modelAck(n);
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        wrPtr         = 0;
        inToken_i     = 1'b0;
        stall_i       = 1'b0;
        resetToggle_i = 1'b0;
        txReady_i     = 1'b0;
        txAbort_i     = 1'b0;
        hsAck_i       = 1'b0;
        hsTimeout_i   = 1'b0;
        doReset();
        test_reset();
        test_mps_split();
        test_nak();
        test_stall();
        test_timeout_retry();
        test_backpressure();
        test_abort();
        test_ack_timeout_same();
        test_reset_toggle();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
